alut_age_scan14: RTL and testbench
==================================

Name: alut_age_scan14

Overview:
Sequences the age-checker port of the dual-port ALUT memory (alut_mem14). On a start request or a periodic tick it sweeps every entry and checks each entry's timestamp against the current time. Valid entries older than the age limit are invalidated. It yields to the address-checker port on any same-address write collision, and reports sweep status and the number of entries removed.

Parameters:
DW, 83, memory word width
DD, 256, memory depth (entries swept per pass)
AW, 8, memory address width (log2 DD)
TW, 32, timestamp width

Ports:
pclk14  in  1  APB clock
n_p_reset14  in  1  asynchronous active-low reset
scan_en14  in  1  aging enable; low aborts the sweep at the next entry boundary
scan_start14  in  1  single-cycle sweep request; ignored while busy
curr_time14  in  TW  free-running current time
age_limit14  in  TW  maximum allowed age; 0 means never invalidate
mem_addr_add14  in  AW  address-checker port address (snooped)
mem_write_add14  in  1  address-checker port write strobe (snooped)
mem_read_data_age14  in  DW  age-port read data from memory
mem_addr_age14  out  AW  age-port address
mem_write_age14  out  1  age-port write strobe
mem_write_data_age14  out  DW  age-port write data
scan_busy14  out  1  sweep in progress
scan_done14  out  1  one-cycle pulse when a sweep completes
aged_evt14  out  1  one-cycle pulse, coincident with each invalidating write
aged_cnt14  out  AW+1  entries invalidated in the last completed sweep

Behaviour:
- Clock and reset: one clock, pclk14. Reset n_p_reset14 is asynchronous, active-low.
- Reset values:
  - FSM in IDLE.
  - All outputs 0; aged_cnt14 = 0.
  - Internal scan address 0, conflict flag 0, running count 0.
- Entry format:
  - [82] valid
  - [81:50] timestamp
  - [49:48] port
  - [47:0] MAC
- Memory read latency is 1 cycle: the address driven in cycle N returns data in cycle N+1.
- FSM states: IDLE, READ, CHECK, WRITE, DONE.
- IDLE:
  - mem_write_age14 = 0; mem_addr_age14 = 0.
  - scan_start14 & scan_en14 sampled high -> READ with scan_addr = 0, running count cleared.
  - scan_busy14 goes high the cycle after start is sampled and stays high through DONE.
- READ:
  - Drive mem_addr_age14 = scan_addr, write = 0. Clear the conflict flag at entry.
  - Next state is CHECK.
- CHECK:
  - Capture mem_read_data_age14.
  - elapsed = curr_time14 - timestamp, computed modulo 2^TW so time wrap-around is handled.
  - stale = valid & (age_limit14 != 0) & (elapsed > age_limit14).
  - stale & !conflict -> WRITE.
  - Otherwise -> advance.
- WRITE:
  - mem_write_data_age14 = captured word with bit 82 cleared; all other bits preserved.
  - mem_write_age14 = 1, combinationally gated low if mem_write_add14 & (mem_addr_add14 == scan_addr) in the same cycle.
  - An ungated write pulses aged_evt14 and increments the running count.
  - Then advance.
- Conflict flag: set when mem_write_add14 & (mem_addr_add14 == scan_addr) during READ or CHECK. A fresh add-path write always wins over ageing.
- Advance:
  - scan_addr == DD-1 -> DONE.
  - Else if scan_en14 low -> IDLE (abort): no done pulse, aged_cnt14 unchanged.
  - Else scan_addr + 1 -> READ.
- DONE: lasts one cycle. scan_done14 = 1, aged_cnt14 <= running count (0..256), then -> IDLE.
- Timing: a sweep takes 2 cycles per non-stale entry and 3 per invalidated entry, plus 1 cycle for DONE.
- Boundary conditions:
  - scan_start14 while busy is ignored.
  - A reset mid-sweep returns to IDLE immediately. Any in-flight write is lost; the memory is unaffected beyond the last completed edge.
  - age_limit14 or curr_time14 changing mid-sweep takes effect on the next CHECK.

Decomposition:
- Package alut_pkg14 holds:
  - field constants VALID_BIT = 82, TS_HI = 81, TS_LO = 50, PORT_HI = 49, PORT_LO = 48, MAC_HI = 47;
  - state encodings;
  - the DW/TW defaults.
- Sub-module alut_age_cmp14 (combinational): inputs curr_time, timestamp, limit, valid; output stale. It isolates the modulo-2^32 compare for unit test.

Test Plan:
- Preload all 256 entries valid, timestamp 100; curr_time 150, age_limit 100; start -> no writes, scan_done14 at start+513 cycles, aged_cnt14 = 0.
- Entries 5 and 255 timestamp 10, others 900; curr_time 1000, limit 100 -> exactly two writes (addresses 5, 255, bit 82 cleared, other bits intact), aged_evt14 twice, aged_cnt14 = 2, sweep 515 cycles.
- Wrap-around: timestamp 0xFFFF_FFF0, curr_time 0x0000_0010, limit 0x40 -> elapsed 0x20, not stale; limit 0x10 -> invalidated.
- Collision: entry 7 stale; address-checker writes address 7 during the READ or CHECK of entry 7 -> no age write to 7, aged_cnt14 excludes it; repeat with the add write in the WRITE cycle -> mem_write_age14 held low.
- Drop scan_en14 while at entry 40 -> returns to IDLE after entry 40, no scan_done14, aged_cnt14 keeps the previous value; scan_start14 while busy -> ignored.
- Assert n_p_reset14 low during WRITE -> all outputs 0 asynchronously, FSM IDLE; a new start after release begins at address 0.

Source files
------------

// File: rtl/alut_pkg14.sv
`default_nettype none
// ============================================================================
// Package  : alut_pkg14
// Desc     : Shared constants for the ALUT age-scan block: entry field
//            positions, FSM state encodings and default dimensions.
// Revision : 1.0 - initial release
// ============================================================================
package alut_pkg14;

  // Default dimensions of the ALUT memory and timestamps
  localparam int DW_DEF = 83;
  localparam int DD_DEF = 256;
  localparam int AW_DEF = 8;
  localparam int TW_DEF = 32;

  // Entry field layout
  localparam int VALID_BIT = 82;
  localparam int TS_HI     = 81;
  localparam int TS_LO     = 50;
  localparam int PORT_HI   = 49;
  localparam int PORT_LO   = 48;
  localparam int MAC_HI    = 47;

  // Sweep FSM encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Structured view of one ALUT entry
  typedef struct packed {
    logic        valid;
    logic [31:0] ts;
    logic [1:0]  port;
    logic [47:0] mac;
  } alut_entry14_t;

endpackage : alut_pkg14
`default_nettype wire

// File: rtl/alut_age_cmp14.sv
`default_nettype none
// ============================================================================
// Module   : alut_age_cmp14
// Desc     : Combinational staleness test for one ALUT entry. The elapsed
//            time is taken modulo 2^TW so a wrapped free-running clock still
//            yields the correct age.
// Revision : 1.0 - initial release
// ============================================================================
module alut_age_cmp14
  import alut_pkg14::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic [TW-1:0] curr_time,
  input  logic [TW-1:0] timestamp,
  input  logic [TW-1:0] limit,
  input  logic          valid,
  output logic          stale
);

  logic [TW-1:0] elapsed;

  // Unsigned subtraction wraps naturally; a zero limit disables ageing
  always_comb begin
    elapsed = curr_time - timestamp;
    stale   = valid & (limit != '0) & (elapsed > limit);
  end

endmodule : alut_age_cmp14
`default_nettype wire

// File: rtl/alut_age_scan14.sv
`default_nettype none
// ============================================================================
// Module   : alut_age_scan14
// Desc     : Age-checker port sequencer for the dual-port ALUT memory.
//            Sweeps every entry, invalidates valid entries older than the
//            age limit, and always yields to a same-address write from the
//            address-checker port.
// Revision : 1.0 - initial release
// ============================================================================
module alut_age_scan14
  import alut_pkg14::*;
#(
  parameter int DW = DW_DEF,
  parameter int DD = DD_DEF,
  parameter int AW = AW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          pclk14,
  input  logic          n_p_reset14,
  input  logic          scan_en14,
  input  logic          scan_start14,
  input  logic [TW-1:0] curr_time14,
  input  logic [TW-1:0] age_limit14,
  input  logic [AW-1:0] mem_addr_add14,
  input  logic          mem_write_add14,
  input  logic [DW-1:0] mem_read_data_age14,
  output logic [AW-1:0] mem_addr_age14,
  output logic          mem_write_age14,
  output logic [DW-1:0] mem_write_data_age14,
  output logic          scan_busy14,
  output logic          scan_done14,
  output logic          aged_evt14,
  output logic [AW:0]   aged_cnt14
);

  logic [2:0]    state_q,     state_d;
  logic [AW-1:0] scan_addr_q, scan_addr_d;
  logic          conflict_q,  conflict_d;
  logic [AW:0]   run_cnt_q,   run_cnt_d;
  logic [AW:0]   aged_cnt_q,  aged_cnt_d;
  logic [DW-1:0] word_q,      word_d;

  logic          add_hit;
  logic          last_entry;
  logic          stale;
  logic          write_ok;
  logic          advance;

  // Address-checker port is writing the entry currently being aged
  assign add_hit    = mem_write_add14 & (mem_addr_add14 == scan_addr_q);
  assign last_entry = (scan_addr_q == AW'(DD - 1));

  // An invalidating write survives only if no add-path write hits it
  assign write_ok   = (state_q == ST_WRITE) & ~add_hit;

  // Staleness of the word returned by the memory during CHECK
  alut_age_cmp14 #(
    .TW (TW)
  ) u_cmp (
    .curr_time (curr_time14),
    .timestamp (mem_read_data_age14[TS_HI:TS_LO]),
    .limit     (age_limit14),
    .valid     (mem_read_data_age14[VALID_BIT]),
    .stale     (stale)
  );

  // Next-state logic: sweep sequencing, conflict tracking and counting
  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    conflict_d  = conflict_q;
    run_cnt_d   = run_cnt_q;
    aged_cnt_d  = aged_cnt_q;
    word_d      = word_q;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (scan_start14 & scan_en14) begin
          state_d     = ST_READ;
          scan_addr_d = '0;
          run_cnt_d   = '0;
          conflict_d  = 1'b0;
        end
      end
      ST_READ: begin
        conflict_d = conflict_q | add_hit;
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        // A collision in this very cycle must also veto the write
        word_d     = mem_read_data_age14;
        conflict_d = conflict_q | add_hit;
        if (stale & ~(conflict_q | add_hit)) begin
          state_d = ST_WRITE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_WRITE: begin
        if (write_ok) begin
          run_cnt_d = run_cnt_q + (AW + 1)'(1);
        end
        advance = 1'b1;
      end
      ST_DONE: begin
        aged_cnt_d = run_cnt_q;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entry boundary: finish, abort on disable, or step to the next entry
    if (advance) begin
      if (last_entry) begin
        state_d = ST_DONE;
      end else if (!scan_en14) begin
        state_d = ST_IDLE;
      end else begin
        state_d     = ST_READ;
        scan_addr_d = scan_addr_q + AW'(1);
        conflict_d  = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge pclk14 or negedge n_p_reset14) begin
    if (!n_p_reset14) begin
      state_q     <= ST_IDLE;
      scan_addr_q <= '0;
      conflict_q  <= 1'b0;
      run_cnt_q   <= '0;
      aged_cnt_q  <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      conflict_q  <= conflict_d;
      run_cnt_q   <= run_cnt_d;
      aged_cnt_q  <= aged_cnt_d;
      word_q      <= word_d;
    end
  end

  // Memory-port outputs decoded from the current state
  always_comb begin
    mem_addr_age14       = '0;
    mem_write_age14      = 1'b0;
    mem_write_data_age14 = '0;
    aged_evt14           = 1'b0;
    case (state_q)
      ST_READ, ST_CHECK: begin
        mem_addr_age14 = scan_addr_q;
      end
      ST_WRITE: begin
        mem_addr_age14                  = scan_addr_q;
        mem_write_data_age14            = word_q;
        mem_write_data_age14[VALID_BIT] = 1'b0;
        mem_write_age14                 = write_ok;
        aged_evt14                      = write_ok;
      end
      default: begin
      end
    endcase
  end

  assign scan_busy14 = (state_q != ST_IDLE);
  assign scan_done14 = (state_q == ST_DONE);
  assign aged_cnt14  = aged_cnt_q;

endmodule : alut_age_scan14
`default_nettype wire

// File: tb/tb_alut_age_scan14.sv
`default_nettype none
// ============================================================================
// Module   : tb_alut_age_scan14
// Desc     : Self-checking bench for alut_age_scan14 with a bench-owned
//            memory and an entry-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alut_age_scan14;

  localparam int DD = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en, scan_start;
  logic [31:0] curr_time, age_limit;
  logic [7:0]  add_addr;
  logic        add_we;
  logic [82:0] add_data;
  logic [82:0] rdata;
  logic [7:0]  age_addr;
  logic        age_we;
  logic [82:0] age_wdata;
  logic        busy, done, evt;
  logic [8:0]  aged_cnt;

  logic [82:0] mem     [DD];
  logic [82:0] ref_mem [DD];
  logic        load_req;
  bit          tick;

  int          n_chk, n_fail, evt_n, done_n, run_cnt;
  bit          exp_on;
  logic [7:0]  exp_addr;
  logic        exp_we, exp_busy, exp_done, exp_evt;
  logic [82:0] exp_wdata;
  logic [8:0]  aged_model;

  always #5 clk = ~clk;

  alut_age_scan14 dut (
    .pclk14               (clk),
    .n_p_reset14          (rst_n),
    .scan_en14            (scan_en),
    .scan_start14         (scan_start),
    .curr_time14          (curr_time),
    .age_limit14          (age_limit),
    .mem_addr_add14       (add_addr),
    .mem_write_add14      (add_we),
    .mem_read_data_age14  (rdata),
    .mem_addr_age14       (age_addr),
    .mem_write_age14      (age_we),
    .mem_write_data_age14 (age_wdata),
    .scan_busy14          (busy),
    .scan_done14          (done),
    .aged_evt14           (evt),
    .aged_cnt14           (aged_cnt)
  );

  // Dual-port memory, 1-cycle read latency; bulk preload from ref_mem
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DD; i++) mem[i] <= ref_mem[i];
    end else begin
      rdata <= mem[age_addr];
      if (age_we) mem[age_addr] <= age_wdata;
      if (add_we) mem[add_addr] <= add_data;
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Age rule: elapsed time modulo 2^32 must exceed a non-zero limit
  function automatic bit f_stale(input logic [82:0] w, input logic [31:0] now, input logic [31:0] lim);
    longint unsigned el;
    el = ((64'(now) + 64'h1_0000_0000) - 64'(w[81:50])) % 64'h1_0000_0000;
    return (w[82] == 1'b1) && (lim != 0) && (el > 64'(lim));
  endfunction

  task automatic set_exp(input int a, input bit we, input logic [82:0] wd,
                         input bit bsy, input bit dn, input bit ev);
    exp_addr  = 8'(a);
    exp_we    = we;
    exp_wdata = wd;
    exp_busy  = bsy;
    exp_done  = dn;
    exp_evt   = ev;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    add_we   = 1'b0;
    add_addr = 8'($urandom_range(0, 255));
    add_data = 83'($urandom);
    if (tick) curr_time = curr_time + 32'd1;
  endtask

  // Address-checker write of a fresh entry; the model sees it immediately
  task automatic add_write(input int a);
    add_we   = 1'b1;
    add_addr = 8'(a);
    add_data = {1'b1, curr_time, 2'b10, 16'hA5A5, 32'($urandom)};
    ref_mem[a] = add_data;
  endtask

  task automatic other_write(input int a);
    int b;
    b = $urandom_range(0, 255);
    if (b != a) add_write(b);
  endtask

  task automatic fill(input bit v, input logic [31:0] ts);
    for (int i = 0; i < DD; i++) ref_mem[i] = {v, ts, 2'(i), 16'h0, 32'($urandom)};
  endtask

  task automatic set_entry(input int i, input bit v, input logic [31:0] ts);
    ref_mem[i] = {v, ts, 2'(i), 16'h5A5A, 32'($urandom)};
  endtask

  task automatic commit();
    load_req = 1'b1;
    next_cycle();
    load_req = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_addr"},  128'(age_addr),  128'(0));
    check({pfx, "_we"},    128'(age_we),    128'(0));
    check({pfx, "_wdata"}, 128'(age_wdata), 128'(0));
    check({pfx, "_busy"},  128'(busy),      128'(0));
    check({pfx, "_done"},  128'(done),      128'(0));
    check({pfx, "_evt"},   128'(evt),       128'(0));
    check({pfx, "_cnt"},   128'(aged_cnt),  128'(0));
  endtask

  // One sweep, walked entry by entry; sets what every cycle must show
  task automatic sweep(input bit rnd, input int coll_addr, input int coll_ph,
                       input int abort_at, input int rst_at, output int done_off);
    logic [82:0] w, wd;
    bit st, cf;
    int ph, cyc;
    done_off = -1;
    run_cnt  = 0;
    cyc      = 0;
    next_cycle();
    scan_en    = 1'b1;
    scan_start = 1'b1;
    set_exp(0, 0, '0, 0, 0, 0);
    for (int a = 0; a < DD; a++) begin
      ph = 0;
      if (rnd) begin
        int r;
        r = $urandom_range(0, 24);
        if (r < 3) ph = r + 1;
      end else if (a == coll_addr) begin
        ph = coll_ph;
      end
      // READ
      next_cycle(); cyc++;
      scan_start = rnd ? ($urandom_range(0, 7) == 0) : (a == 20);
      w = ref_mem[a];
      if (ph == 1) add_write(a);
      else if (rnd && $urandom_range(0, 7) == 0) other_write(a);
      set_exp(a, 0, '0, 1, 0, 0);
      // CHECK
      next_cycle(); cyc++;
      scan_start = 1'b0;
      if (a == abort_at) scan_en = 1'b0;
      if (ph == 2) add_write(a);
      else if (rnd && $urandom_range(0, 7) == 0) other_write(a);
      st = f_stale(w, curr_time, age_limit);
      cf = (ph == 1) || (ph == 2);
      set_exp(a, 0, '0, 1, 0, 0);
      // WRITE
      if (st && !cf) begin
        next_cycle(); cyc++;
        if (ph == 3) add_write(a);
        else if (rnd && $urandom_range(0, 7) == 0) other_write(a);
        wd = w;
        wd[82] = 1'b0;
        set_exp(a, ph != 3, wd, 1, 0, ph != 3);
        if (a == rst_at) begin
          exp_on = 1'b0;
          #1 rst_n = 1'b0;
          #1 check_zero("rst_async");
          @(posedge clk);
          #1;
          rst_n      = 1'b1;
          add_we     = 1'b0;
          scan_en    = 1'b1;
          aged_model = '0;
          set_exp(0, 0, '0, 0, 0, 0);
          exp_on = 1'b1;
          return;
        end
        if (ph != 3) begin
          ref_mem[a] = wd;
          run_cnt++;
        end
      end
      if (a == abort_at && a != DD - 1) begin
        next_cycle();
        set_exp(0, 0, '0, 0, 0, 0);
        return;
      end
    end
    // DONE
    next_cycle(); cyc++;
    set_exp(0, 0, '0, 1, 1, 0);
    done_off = cyc;
    next_cycle();
    aged_model = 9'(run_cnt);
    set_exp(0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    int d, e0, d0;
    logic [82:0] o5, o255;
    n_chk = 0; n_fail = 0; evt_n = 0; done_n = 0;
    exp_on = 1'b0; tick = 1'b0; load_req = 1'b0;
    rst_n = 1'b0; scan_en = 1'b0; scan_start = 1'b0;
    curr_time = '0; age_limit = '0;
    add_addr = '0; add_we = 1'b0; add_data = '0;
    aged_model = '0;
    set_exp(0, 0, '0, 0, 0, 0);

    // Per-cycle comparison of DUT outputs against the model
    fork
      forever begin
        @(negedge clk);
        if (evt === 1'b1) evt_n++;
        if (done === 1'b1) done_n++;
        if (exp_on) begin
          check("addr", 128'(age_addr), 128'(exp_addr));
          check("we",   128'(age_we),   128'(exp_we));
          if (exp_we) check("wdata", 128'(age_wdata), 128'(exp_wdata));
          check("busy", 128'(busy),     128'(exp_busy));
          check("done", 128'(done),     128'(exp_done));
          check("evt",  128'(evt),      128'(exp_evt));
          check("cnt",  128'(aged_cnt), 128'(aged_model));
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n  = 1'b1;
    exp_on = 1'b1;

    // Hand-worked anchors for the age rule
    check("model_wrap_young", 128'(f_stale({1'b1, 32'hFFFF_FFF0, 50'h0}, 32'h10, 32'h40)), 128'(0));
    check("model_wrap_old",   128'(f_stale({1'b1, 32'hFFFF_FFF0, 50'h0}, 32'h10, 32'h10)), 128'(1));
    check("model_lim_zero",   128'(f_stale({1'b1, 32'h0, 50'h0}, 32'hFFFF, 32'h0)), 128'(0));

    // All entries young: no writes, 513-cycle sweep
    curr_time = 32'd150; age_limit = 32'd100;
    fill(1'b1, 32'd100); commit();
    d0 = done_n;
    sweep(0, -1, 0, -1, -1, d);
    check("t1_done_cycle", 128'(d), 128'(513));
    check("t1_aged_cnt",   128'(aged_cnt), 128'(0));
    check("t1_done_pulses", 128'(done_n - d0), 128'(1));

    // Entries 5 and 255 stale
    curr_time = 32'd1000;
    fill(1'b1, 32'd900); set_entry(5, 1'b1, 32'd10); set_entry(255, 1'b1, 32'd10);
    o5 = ref_mem[5]; o255 = ref_mem[255];
    commit();
    e0 = evt_n;
    sweep(0, -1, 0, -1, -1, d);
    check("t2_done_cycle", 128'(d), 128'(515));
    check("t2_aged_cnt",   128'(aged_cnt), 128'(2));
    check("t2_evt_pulses", 128'(evt_n - e0), 128'(2));
    check("t2_mem5",   128'(mem[5]),   128'({1'b0, o5[81:0]}));
    check("t2_mem255", 128'(mem[255]), 128'({1'b0, o255[81:0]}));

    // Timestamp wrap-around
    curr_time = 32'h0000_0010; age_limit = 32'h40;
    fill(1'b0, 32'h0); set_entry(0, 1'b1, 32'hFFFF_FFF0); commit();
    sweep(0, -1, 0, -1, -1, d);
    check("t3_wrap_young_cnt", 128'(aged_cnt), 128'(0));
    age_limit = 32'h10;
    sweep(0, -1, 0, -1, -1, d);
    check("t3_wrap_old_cnt", 128'(aged_cnt), 128'(1));

    // Collision on entry 7 in READ, CHECK and WRITE
    curr_time = 32'd5000; age_limit = 32'd100;
    for (int ph = 1; ph <= 3; ph++) begin
      fill(1'b1, 32'd4990); set_entry(7, 1'b1, 32'd10); commit();
      sweep(0, 7, ph, -1, -1, d);
      check("t4_coll_cnt",   128'(aged_cnt), 128'(0));
      check("t4_coll_valid", 128'(mem[7][82]), 128'(1));
    end

    // Abort at entry 40 keeps the previous count; start while busy ignored
    fill(1'b1, 32'd4990); set_entry(3, 1'b1, 32'd1); set_entry(50, 1'b1, 32'd1); commit();
    sweep(0, -1, 0, -1, -1, d);
    check("t5_setup_cnt", 128'(aged_cnt), 128'(2));
    fill(1'b1, 32'd4990); set_entry(10, 1'b1, 32'd1); set_entry(30, 1'b1, 32'd1);
    set_entry(60, 1'b1, 32'd1); commit();
    d0 = done_n;
    sweep(0, -1, 0, 40, -1, d);
    repeat (3) next_cycle();
    check("t5_abort_cnt",   128'(aged_cnt), 128'(2));
    check("t5_abort_nodone", 128'(done_n - d0), 128'(0));
    check("t5_mem30_aged",  128'(mem[30][82]), 128'(0));
    check("t5_mem60_kept",  128'(mem[60][82]), 128'(1));

    // Reset during the WRITE of entry 3, then a clean sweep from address 0
    fill(1'b1, 32'd4990); set_entry(3, 1'b1, 32'd1); commit();
    sweep(0, -1, 0, -1, 3, d);
    next_cycle();
    check("t6_write_lost", 128'(mem[3][82]), 128'(1));
    sweep(0, -1, 0, -1, -1, d);
    check("t6_after_rst_cnt", 128'(aged_cnt), 128'(1));
    check("t6_mem3_aged",     128'(mem[3][82]), 128'(0));

    // Randomized sweeps with free-running time and snooped traffic
    tick = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int span;
      curr_time = $urandom;
      age_limit = (k == 1) ? 32'd0 : 32'($urandom_range(1, 600));
      span = (age_limit == 0) ? 1000 : 2 * int'(age_limit) + 400;
      for (int i = 0; i < DD; i++)
        ref_mem[i] = {($urandom_range(0, 3) != 0), curr_time - 32'($urandom_range(0, span)),
                      2'(i), 16'h0, 32'($urandom)};
      commit();
      sweep(1, -1, 0, (k == 3) ? $urandom_range(10, 200) : -1, -1, d);
      repeat (2) next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_alut_age_scan14
`default_nettype wire
